// File: rtl/shift_share_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_share_pkg
// Description : Shared types and constants for the shift-register sharing
//               controller (FSM state encoding, requester count, counter
//               width helper).
// Revision    : 1.0 - initial release
// ============================================================================
package shift_share_pkg;

  // Controller states; PARITY is only reachable when the parity bit is built in
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Number of requesters sharing the shifter
  localparam int NUM_REQ = 2;

  // Bit counter width able to hold 0..width
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-input round-robin arbiter. A lone requester always wins;
//               with both requesting, the one not granted last wins. The
//               last-grant pointer updates on every issued grant.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import shift_share_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               grant_en,
  output logic [NUM_REQ-1:0] grant
);

  // 1 when requester 1 received the most recent grant; resets to 1 so that
  // requester 0 is favoured on the first contested request
  logic last_was_1;

  // Pick the winner from the request vector and the last-grant pointer
  always_comb begin
    grant = '0;
    if (grant_en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_was_1 ? 2'b01 : 2'b10;
        default: grant = '0;
      endcase
    end
  end

  // Remember who was granted last
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_was_1 <= 1'b1;
    end else if (|grant) begin
      last_was_1 <= grant[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/shift_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift_share_ctrl
// Description : Shares one parallel-in/serial-out shift register between two
//               valid/ready requesters. Grants round-robin, loads the winning
//               word, shifts it out LSB-first honouring a downstream stall,
//               and pulses o_Done once the frame's last bit is taken.
//               Optional feature macro: SHIFT_SHARE_PARITY_EN appends an even
//               parity bit (XOR of the data bits) to each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_share_ctrl
  import shift_share_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic [NUM_REQ-1:0]         i_Req_Valid,
  input  logic [NUM_REQ*WIDTH-1:0]   i_Req_Data,
  output logic [NUM_REQ-1:0]         o_Req_Ready,
  output logic                       o_Ser_Data,
  output logic                       o_Ser_Valid,
  output logic                       o_Ser_Last,
  output logic                       o_Ser_Id,
  input  logic                       i_Ser_Stall,
  output logic                       o_Done,
  output logic                       o_Done_Id
);

  localparam int CW = cnt_width(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   shreg;
  logic [CW-1:0]      cnt;
  logic               owner;
  logic               done_q;
  logic               done_id_q;
  logic [NUM_REQ-1:0] grant;
  logic               grant_en;
  logic               winner;
  logic [WIDTH-1:0]   win_word;
  logic               last_data;
`ifdef SHIFT_SHARE_PARITY_EN
  logic               parity;
`endif

  // Grants are only offered while idle and never while reset is held, so a
  // request cannot be acknowledged without its word being captured
  assign grant_en  = (state == IDLE) && !i_Reset;
  assign winner    = grant[1];
  assign win_word  = winner ? i_Req_Data[WIDTH +: WIDTH] : i_Req_Data[0 +: WIDTH];
  assign last_data = (cnt == CW'(WIDTH - 1));

  rr_arbiter2 u_arb (
    .clk      (i_Clock),
    .rst      (i_Reset),
    .req      (i_Req_Valid),
    .grant_en (grant_en),
    .grant    (grant)
  );

  assign o_Req_Ready = grant;
  assign o_Ser_Valid = (state != IDLE);
  assign o_Ser_Id    = owner;
  assign o_Done      = done_q;
  assign o_Done_Id   = done_id_q;

`ifdef SHIFT_SHARE_PARITY_EN
  assign o_Ser_Data  = (state == PARITY) ? parity : shreg[0];
  assign o_Ser_Last  = (state == PARITY);
`else
  assign o_Ser_Data  = shreg[0];
  assign o_Ser_Last  = (state == SHIFT) && last_data;
`endif

  // Frame sequencer: load on grant, shift on each un-stalled cycle, pulse done
  // on the cycle after the final bit is taken
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      owner     <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
`ifdef SHIFT_SHARE_PARITY_EN
      parity    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|grant) begin
            shreg <= win_word;
            cnt   <= '0;
            owner <= winner;
`ifdef SHIFT_SHARE_PARITY_EN
            parity <= ^win_word;
`endif
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (!i_Ser_Stall) begin
            shreg <= shreg >> 1;
            cnt   <= cnt + 1'b1;
            if (last_data) begin
`ifdef SHIFT_SHARE_PARITY_EN
              state <= PARITY;
`else
              state     <= IDLE;
              done_q    <= 1'b1;
              done_id_q <= owner;
`endif
            end
          end
        end
`ifdef SHIFT_SHARE_PARITY_EN
        PARITY: begin
          if (!i_Ser_Stall) begin
            state     <= IDLE;
            done_q    <= 1'b1;
            done_id_q <= owner;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/shift_share_ctrl.md
# shift_share_ctrl

Controller that shares one parallel-in/serial-out shift register between two requesters. It arbitrates round-robin between two valid/ready request ports, loads the granted word into the shifter, and sequences it out LSB-first one bit per cycle, honouring a downstream stall. It sits between the word-level producers and the serial link.

## Interface

- WIDTH, 8, data word width in bits; legal range 2..32.
- i_Clock  in  1  sole clock, rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Req_Valid  in  2  bit k: requester k has a word pending.
- i_Req_Data  in  2*WIDTH  requester k word at [k*WIDTH +: WIDTH].
- o_Req_Ready  out  2  bit k: requester k's word is accepted this cycle.
- o_Ser_Data  out  1  current serial bit.
- o_Ser_Valid  out  1  o_Ser_Data is meaningful.
- o_Ser_Last  out  1  current bit is the final bit of the frame.
- o_Ser_Id  out  1  requester that owns the current frame.
- i_Ser_Stall  in  1  downstream cannot take the bit; hold it.
- o_Done  out  1  one-cycle pulse after a frame's last bit is taken.
- o_Done_Id  out  1  owner of the frame that just completed; valid with o_Done.
- One clock; reset is asynchronous and active-high.

## Operation

- States: IDLE, SHIFT, plus PARITY when SHIFT_SHARE_PARITY_EN is defined.
- IDLE: if any i_Req_Valid bit is set, the arbiter picks a winner k; o_Req_Ready[k]=1 that cycle only (combinational on valid and state); the word is captured into the shift register; the bit counter is cleared; the owner register is set to k; the state moves to SHIFT.
- Arbitration: with a single valid requester, that requester wins. With both valid, the requester not granted last wins. The pointer updates on each grant.
- SHIFT: o_Ser_Valid=1 and o_Ser_Data = shift register bit 0. A bit is taken on any cycle with i_Ser_Stall=0; the register then shifts right and the counter increments. When a stall is present, all state holds.
- On the taken bit WIDTH-1: go to PARITY if it is compiled in; otherwise go to IDLE.
- o_Ser_Last=1 on the final bit of the frame only, which is the data bit WIDTH-1 or the parity bit.
- Entering IDLE from a completed frame: o_Done=1 and o_Done_Id=owner for that single cycle. A new grant may occur in that same cycle.
- i_Ser_Stall is ignored in IDLE. The parity accumulator is computed over the captured word.
- Reset (asserted at any time, including mid-frame): the frame is abandoned with no o_Done. State goes to IDLE, the pointer favours requester 0, and the shift register, counter and owner are zeroed.
- Reset values: o_Req_Ready=0 and o_Ser_Data/Valid/Last/Id=0. o_Done=0 and o_Done_Id=0.

## Timing

- Handshake at cycle T: first bit valid at T+1. With no stalls, data bit j appears at T+1+j, and the last data bit at T+WIDTH.
- Each stall cycle delays all later bits by one cycle.
- o_Done is at T+WIDTH+1, or T+WIDTH+2 with parity, plus the number of stall cycles.
- Back-to-back frames have exactly one idle serial cycle (o_Ser_Valid=0) between them.
- Requesters must hold valid and data stable until ready. Deasserting valid before ready is allowed, and the request is then withdrawn.

## Configuration

- SHIFT_SHARE_PARITY_EN defined:
  - One extra bit follows each frame: even parity, equal to the XOR of the WIDTH data bits.
  - The frame is WIDTH+1 bits long, and o_Ser_Last marks the parity bit.
- Undefined:
  - The PARITY state and its logic are absent.
  - The frame is WIDTH bits long.

## Structure

- Package shift_share_pkg holds:
  - the state enum typedef (IDLE, SHIFT, PARITY);
  - the constant NUM_REQ=2;
  - the counter-width function $clog2(WIDTH+1).
- Sub-module rr_arbiter2:
  - two-input round-robin arbiter with a registered last-grant pointer;
  - inputs: request vector and grant-enable; outputs: one-hot grant.
- Top level holds the FSM, the shift register, the bit counter and the owner register.

## Test plan

- WIDTH=8, requester 0 sends 0xA5, no stall -> o_Ser_Data is 1,0,1,0,0,1,0,1 on T+1..T+8, o_Ser_Last at T+8, o_Done with Id=0 at T+9.
- Both requesters valid continuously, with words 0x0F and 0xF0 -> grants alternate 0,1,0,1, each frame is correct, and there is one idle cycle between frames.
- Stall asserted for 3 cycles during bit 4 of 0x3C -> bit 4 is held for 4 cycles, the sequence is intact, and o_Done arrives 3 cycles late.
- Reset asserted during bit 5 -> all outputs are 0 immediately, no o_Done, and requester 0 wins the next simultaneous request.
- With SHIFT_SHARE_PARITY_EN, word 0x07 -> a ninth bit of 1 carries o_Ser_Last, and o_Done arrives at T+10.
- Requester 1 drops valid before it is granted while requester 0 shifts -> no grant to 1 and no spurious o_Req_Ready.
